sum_display_scan: RTL and testbench

SUM_DISPLAY_SCAN -- requirements
Module: sum_display_scan

---
 rtl/sum_display_scan.sv | 158 +++++++++++++++
 tb/tb_sum_display_scan.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_display_scan.sv
// Four-digit multiplexed seven-segment scanner for a 5-bit adder result.
// The right two digits show the value in decimal (leading tens blanked), the
// left two in hex, with the decimal point lit on the hex low digit as a
// visual separator. The value shown is latched once per frame so that a
// switch change never mixes two values across the four digits.
module sum_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum,
  input  logic       en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int            CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] COUNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] SLOT_UNITS  = 2'd0;
  localparam logic [1:0] SLOT_TENS   = 2'd1;
  localparam logic [1:0] SLOT_HEX_LO = 2'd2;
  localparam logic [1:0] SLOT_HEX_HI = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [CW-1:0] count;
  logic          tick;
  logic [1:0]    index;
  logic [4:0]    disp;

  logic [3:0]    units;
  logic [3:0]    tens;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          dp_next;

  // Active-low segment pattern for one hex digit, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  // Two-flop synchronizer: the switches are asynchronous to clk.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the
    // pre-edge value of the others; with = the two stages would collapse.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sum;
      sync2 <= sync1;
    end
  end

  assign tick = (count == COUNT_LAST);

  // Refresh divider: each digit stays lit for REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Digit index advances on each tick and wraps 3 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= SLOT_UNITS;
    end else if (tick) begin
      index <= index + 1'b1;
    end
  end

  // Display value only changes at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
    end else if (tick && (index == SLOT_HEX_HI)) begin
      disp <= sync2;
    end
  end

  assign units = 4'(disp % 5'd10);
  assign tens  = 4'(disp / 5'd10);

  // Pick the digit and anode for the current slot; blank on en=0 or zero tens.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    seg_next = SEG_BLANK;
    an_next  = AN_OFF;
    dp_next  = 1'b1;
    if (en) begin
      case (index)
        SLOT_UNITS: begin
          seg_next = hex_to_seg(units);
          an_next  = 4'b1110;
        end
        SLOT_TENS: begin
          if (tens != 4'd0) begin
            seg_next = hex_to_seg(tens);
            an_next  = 4'b1101;
          end
        end
        SLOT_HEX_LO: begin
          seg_next = hex_to_seg(disp[3:0]);
          an_next  = 4'b1011;
          dp_next  = 1'b0;
        end
        default: begin
          seg_next = hex_to_seg({3'b000, disp[4]});
          an_next  = 4'b0111;
        end
      endcase
    end
  end

  // Registered pin drivers: glitch-free outputs, one cycle behind the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sum_display_scan.sv
// Self-checking bench for sum_display_scan with REFRESH_DIV=4. The reference
// model works from the cycle number since reset and a history of the sum
// input: slot = (cycle/4)%4, and the value shown is the sum seen two cycles
// before the last frame boundary.
module tb_sum_display_scan;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk;
  logic       rst;
  logic [4:0] sum;
  logic       en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  sum_display_scan #(.REFRESH_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .sum (sum),
    .en  (en),
    .seg (seg),
    .an  (an),
    .dp  (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         hist[$];
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp;
  int         m_c, m_m, m_v, m_slot;

  function automatic logic [11:0] model_out(input int slot, input int v, input logic e);
    logic [6:0] s;
    logic [3:0] a;
    logic       d;
    int         digit;
    s = 7'b1111111;
    a = 4'b1111;
    d = 1'b1;
    if (e) begin
      case (slot)
        0:       digit = v % 10;
        1:       digit = v / 10;
        2:       digit = v % 16;
        default: digit = v / 16;
      endcase
      if (!(slot == 1 && digit == 0)) begin
        s = SEG_TAB[digit];
        a = ~(4'b0001 << slot);
      end
      if (slot == 2) d = 1'b0;
    end
    return {s, a, d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      {exp_seg, exp_an, exp_dp} = {7'b1111111, 4'b1111, 1'b1};
    end else begin
      m_c = hist.size();
      hist.push_back(int'(sum));
      m_slot = (m_c / D) % 4;
      m_m = m_c / FRAME;
      m_v = (m_m == 0) ? 0 : hist[FRAME * m_m - 3];
      {exp_seg, exp_an, exp_dp} = model_out(m_slot, m_v, en);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    sum = 5'd23;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {7'b1111111, 4'b1111, 1'b1}) begin
        errors++;
        $display("FAIL reset cycle %0d: got seg=%b an=%b dp=%b want seg=1111111 an=1111 dp=1",
                 i, seg, an, dp);
      end
    end
  endtask

  task automatic test_frame_decode();
    int run;
    bit found;
    rst = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL decode23 cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    // Units slot of value 23 must show '3' for exactly 4 consecutive cycles.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110) found = 1'b1;
    end
    run = 0;
    if (found) begin
      while (an == 4'b1110 && seg == 7'b0110000 && run < 8) begin
        run++;
        @(negedge clk);
      end
    end
    checks++;
    if (run != 4) begin
      errors++;
      $display("FAIL slot_length: got %0d cycles of units '3' want 4", run);
    end
  endtask

  task automatic test_blanking();
    int blank_cycles;
    sum = 5'd5;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL blank5 cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    blank_cycles = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an == 4'b1111 && seg == 7'b1111111) blank_cycles++;
    end
    checks++;
    if (blank_cycles != 4) begin
      errors++;
      $display("FAIL blank_tens: got %0d blank cycles per frame want 4", blank_cycles);
    end
  endtask

  task automatic test_frame_integrity();
    bit found;
    logic [6:0] want [3];
    logic [3:0] want_an [3];
    want[0] = 7'b1111000; want_an[0] = 4'b1011;  // '7' of 23, same frame
    want[1] = 7'b1000000; want_an[1] = 4'b1110;  // units '0' of 10, next frame
    want[2] = 7'b0001000; want_an[2] = 4'b1011;  // hex 'A' of 10
    sum = 5'd23;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL settle23 cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if (hist.size() % FRAME == D + 1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL integrity_align: index 1 not reached within %0d cycles", FRAME);
    end
    sum = 5'd10;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < FRAME && !found; i++) begin
        @(negedge clk);
        checks++;
        if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
          errors++;
          $display("FAIL integrity cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                   i, seg, an, dp, exp_seg, exp_an, exp_dp);
        end
        if (an == want_an[k]) found = 1'b1;
      end
      checks++;
      if (!found || seg !== want[k]) begin
        errors++;
        $display("FAIL integrity_digit%0d: got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, want_an[k], want[k]);
      end
    end
  endtask

  task automatic test_enable();
    bit found;
    sum = 5'd31;
    en  = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'b1111 || dp !== 1'b1 || {seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL enable_off cycle %0d: got seg=%b an=%b dp=%b want an=1111 dp=1",
                 i, seg, an, dp);
      end
    end
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if (hist.size() % FRAME == D + 2) found = 1'b1;
      else @(negedge clk);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (!found || {seg, an, dp} !== {7'b0110000, 4'b1101, 1'b1}) begin
      errors++;
      $display("FAIL enable_resume: got seg=%b an=%b dp=%b want seg=0110000 an=1101 dp=1",
               seg, an, dp);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL enable_on cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if (hist.size() % FRAME == 2 * D + 1) found = 1'b1;
      else @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!found || {seg, an, dp} !== {7'b1111111, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL midreset_pattern: got seg=%b an=%b dp=%b want seg=1111111 an=1111 dp=1",
               seg, an, dp);
    end
    rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {7'b1000000, 4'b1110, 1'b1}) begin
        errors++;
        $display("FAIL midreset_idx0 cycle %0d: got seg=%b an=%b dp=%b want seg=1000000 an=1110 dp=1",
                 i, seg, an, dp);
      end
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL midreset_after cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        errors++;
        $display("FAIL random cycle %0d: got seg=%b an=%b dp=%b want seg=%b an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      rst = 1'b0;
      if ($urandom_range(0, 9) == 0) sum = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_decode();
    test_blanking();
    test_frame_integrity();
    test_enable();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
